readout_sequencer: RTL and testbench

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

---
 rtl/readout_sequencer_pkg.sv | 25 ++
 rtl/readout_sequencer_if.sv | 31 +++
 rtl/seq_down_counter.sv | 37 +++
 rtl/readout_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_readout_sequencer.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/readout_sequencer_pkg.sv
// rtl/readout_sequencer_pkg.sv - shared state type, default widths and width helper for the readout sequencer
package readout_sequencer_pkg;

    localparam int SHOT_W_DEF         = 16;
    localparam int DELAY_W_DEF        = 14;
    localparam int LEN_W_DEF          = 11;
    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_MARGIN_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TRIG = 3'd1,
        ST_DELAY     = 3'd2,
        ST_COLLECT   = 3'd3,
        ST_HOLD      = 3'd4
    } seq_state_t;

    // Watchdog must hold sample_length + margin without overflow, so one bit wider than the larger operand.
    function automatic int wd_width(input int len_w, input int margin);
        int m;
        m = $clog2(margin);
        return ((len_w > m) ? len_w : m) + 1;
    endfunction

endpackage

// File: rtl/readout_sequencer_if.sv
// rtl/readout_sequencer_if.sv - result stream bundle between the sequencer and its consumer
interface readout_sequencer_if
    import readout_sequencer_pkg::*;
#(
    parameter int SHOT_W = SHOT_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_i;
    logic [DATA_W-1:0] res_q;
    logic [SHOT_W-1:0] res_shot;

    modport master (
        output res_valid,
        output res_i,
        output res_q,
        output res_shot,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_i,
        input  res_q,
        input  res_shot,
        output res_ready
    );

endinterface

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down counter that saturates at zero and flags it
module seq_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority; counting stops at zero so an idle enable cannot wrap the counter.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/readout_sequencer.sv
// rtl/readout_sequencer.sv - per-shot trigger/delay/collect/result sequencer for qubit readout
module readout_sequencer
    import readout_sequencer_pkg::*;
#(
    parameter int SHOT_W         = SHOT_W_DEF,
    parameter int DELAY_W        = DELAY_W_DEF,
    parameter int LEN_W          = LEN_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_MARGIN = TIMEOUT_MARGIN_DEF
) (
    input  logic               clk100,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic [SHOT_W-1:0]  num_shots,
    input  logic [DELAY_W-1:0] delay_time,
    input  logic [LEN_W-1:0]   sample_length,
    input  logic               trigger,
    output logic               start_collect,
    input  logic               iq_valid,
    input  logic [DATA_W-1:0]  i_val,
    input  logic [DATA_W-1:0]  q_val,
    readout_sequencer_if.master res,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    output logic               timeout_err
);

    localparam int WD_W = wd_width(LEN_W, TIMEOUT_MARGIN);

    seq_state_t         state_q;
    logic               trig_q;
    logic [SHOT_W-1:0]  num_shots_q;
    logic [DELAY_W-1:0] delay_q;
    logic [LEN_W-1:0]   len_q;
    logic [SHOT_W-1:0]  shot_q;
    logic               start_collect_q;
    logic               done_q;
    logic               overrun_q;
    logic               timeout_q;
    logic               res_valid_q;
    logic [DATA_W-1:0]  res_i_q;
    logic [DATA_W-1:0]  res_q_q;
    logic [SHOT_W-1:0]  res_shot_q;

    logic               trig_edge;
    logic               dly_load;
    logic               dly_zero;
    logic               wd_zero;
    logic               go_collect;
    logic               last_shot;
    logic [DELAY_W-1:0] dly_load_val;
    logic [WD_W-1:0]    wd_load_val;

    assign trig_edge    = trigger & ~trig_q;
    assign last_shot    = (shot_q == (num_shots_q - SHOT_W'(1)));
    // Delay counter is loaded with delay-1 so that its zero cycle is the last DELAY cycle.
    assign dly_load_val = delay_q - DELAY_W'(1);
    assign wd_load_val  = WD_W'(len_q) + WD_W'(TIMEOUT_MARGIN);
    assign dly_load     = !abort && (state_q == ST_WAIT_TRIG) && trig_edge && (delay_q != '0);
    assign go_collect   = !abort &&
                          (((state_q == ST_WAIT_TRIG) && trig_edge && (delay_q == '0)) ||
                           ((state_q == ST_DELAY) && dly_zero));

    seq_down_counter #(.W(DELAY_W)) u_delay_cnt (
        .clk        (clk100),
        .reset      (reset),
        .load_i     (dly_load),
        .load_val_i (dly_load_val),
        .en_i       (state_q == ST_DELAY),
        .zero_o     (dly_zero)
    );

    seq_down_counter #(.W(WD_W)) u_watchdog (
        .clk        (clk100),
        .reset      (reset),
        .load_i     (go_collect),
        .load_val_i (wd_load_val),
        .en_i       (state_q == ST_COLLECT),
        .zero_o     (wd_zero)
    );

    // Sequencer FSM with all outputs registered; abort overrides every other event.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            trig_q          <= 1'b0;
            num_shots_q     <= '0;
            delay_q         <= '0;
            len_q           <= '0;
            shot_q          <= '0;
            start_collect_q <= 1'b0;
            done_q          <= 1'b0;
            overrun_q       <= 1'b0;
            timeout_q       <= 1'b0;
            res_valid_q     <= 1'b0;
            res_i_q         <= '0;
            res_q_q         <= '0;
            res_shot_q      <= '0;
        end else begin
            trig_q          <= trigger;
            start_collect_q <= 1'b0;
            done_q          <= 1'b0;
            if (abort) begin
                state_q     <= ST_IDLE;
                res_valid_q <= 1'b0;
            end else begin
                // An edge outside WAIT_TRIG is dropped but remembered as an overrun.
                if (trig_edge && (state_q inside {ST_DELAY, ST_COLLECT, ST_HOLD})) begin
                    overrun_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (arm) begin
                            overrun_q <= 1'b0;
                            timeout_q <= 1'b0;
                            if (num_shots != '0) begin
                                num_shots_q <= num_shots;
                                delay_q     <= delay_time;
                                len_q       <= sample_length;
                                shot_q      <= '0;
                                state_q     <= ST_WAIT_TRIG;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (go_collect) begin
                            start_collect_q <= 1'b1;
                            state_q         <= ST_COLLECT;
                        end else if (trig_edge) begin
                            state_q <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (go_collect) begin
                            start_collect_q <= 1'b1;
                            state_q         <= ST_COLLECT;
                        end
                    end
                    ST_COLLECT: begin
                        if (iq_valid) begin
                            res_i_q     <= i_val;
                            res_q_q     <= q_val;
                            res_shot_q  <= shot_q;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else if (wd_zero) begin
                            timeout_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (res.res_ready) begin
                            res_valid_q <= 1'b0;
                            if (last_shot) begin
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                shot_q  <= shot_q + SHOT_W'(1);
                                state_q <= ST_WAIT_TRIG;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign start_collect = start_collect_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign overrun       = overrun_q;
    assign timeout_err   = timeout_q;
    assign res.res_valid = res_valid_q;
    assign res.res_i     = res_i_q;
    assign res.res_q     = res_q_q;
    assign res.res_shot  = res_shot_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// tb/tb_readout_sequencer.sv - scoreboard testbench for the readout sequencer
module tb_readout_sequencer;

    typedef struct packed {
        logic [15:0] shot;
        logic [31:0] i;
        logic [31:0] q;
    } exp_t;

    logic        clk100 = 1'b0;
    logic        reset;
    logic        arm;
    logic        abort;
    logic [15:0] num_shots;
    logic [13:0] delay_time;
    logic [10:0] sample_length;
    logic        trigger;
    logic        start_collect;
    logic        iq_valid;
    logic [31:0] i_val;
    logic [31:0] q_val;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        timeout_err;

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   start_cnt = 0;
    int   done_cnt  = 0;
    exp_t exp_q[$];

    readout_sequencer_if #(.SHOT_W(16), .DATA_W(32)) res_if ();

    readout_sequencer #(
        .SHOT_W(16), .DELAY_W(14), .LEN_W(11), .DATA_W(32), .TIMEOUT_MARGIN(64)
    ) dut (
        .clk100        (clk100),
        .reset         (reset),
        .arm           (arm),
        .abort         (abort),
        .num_shots     (num_shots),
        .delay_time    (delay_time),
        .sample_length (sample_length),
        .trigger       (trigger),
        .start_collect (start_collect),
        .iq_valid      (iq_valid),
        .i_val         (i_val),
        .q_val         (q_val),
        .res           (res_if),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    always @(negedge clk100) begin
        if (start_collect) start_cnt++;
        if (done) done_cnt++;
    end

    // Result scoreboard: every accepted result must match the oldest expectation.
    always @(negedge clk100) begin
        exp_t e;
        if (res_if.res_valid && res_if.res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL result_unexpected shot=%0d i=%h q=%h", res_if.res_shot, res_if.res_i, res_if.res_q);
            end else begin
                e = exp_q.pop_front();
                if ({res_if.res_shot, res_if.res_i, res_if.res_q} !== {e.shot, e.i, e.q}) begin
                    failures++;
                    $display("FAIL result_data got shot=%0d i=%h q=%h exp shot=%0d i=%h q=%h",
                             res_if.res_shot, res_if.res_i, res_if.res_q, e.shot, e.i, e.q);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "simulation did not complete");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk100);
            #2;
        end
    endtask

    task automatic do_arm(input int n, input int d, input int l);
        num_shots     = 16'(n);
        delay_time    = 14'(d);
        sample_length = 11'(l);
        arm           = 1'b1;
        tick();
        arm           = 1'b0;
    endtask

    task automatic pulse_trigger(output int t);
        t       = cyc;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_start(input int limit, output int s);
        s = -1;
        for (int k = 0; k < limit && s < 0; k++) begin
            if (start_collect) s = cyc;
            else tick();
        end
    endtask

    task automatic send_iq(input int shot, input bit push, output logic [31:0] i, output logic [31:0] q);
        exp_t e;
        i        = $urandom;
        q        = $urandom;
        i_val    = i;
        q_val    = q;
        iq_valid = 1'b1;
        if (push) begin
            e.shot = 16'(shot);
            e.i    = i;
            e.q    = q;
            exp_q.push_back(e);
        end
        tick();
        iq_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, start_collect, res_if.res_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, start_collect, res_if.res_valid});
        end
        checks++;
        if ({overrun, timeout_err} !== 2'b00) begin
            failures++;
            $display("FAIL reset_sticky got=%b exp=00", {overrun, timeout_err});
        end
        checks++;
        if ({res_if.res_i, res_if.res_q, res_if.res_shot} !== 80'd0) begin
            failures++;
            $display("FAIL reset_data got i=%h q=%h shot=%0d exp=0", res_if.res_i, res_if.res_q, res_if.res_shot);
        end
    endtask

    task automatic test_multi_shot();
        int t, s, d0, st0;
        logic [31:0] i, q;
        res_if.res_ready = 1'b1;
        d0  = done_cnt;
        st0 = start_cnt;
        do_arm(3, 5, 100);
        for (int n = 0; n < 3; n++) begin
            tick(2);
            pulse_trigger(t);
            wait_start(50, s);
            checks++;
            if (s != t + 6) begin
                failures++;
                $display("FAIL multi_start_latency shot=%0d got=%0d exp=6", n, s - t);
            end
            tick(100);
            send_iq(n, 1'b1, i, q);
            tick(2);
        end
        tick(3);
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL multi_done got done=%0d busy=%b exp done=1 busy=0", done_cnt - d0, busy);
        end
        checks++;
        if (start_cnt - st0 != 3) begin
            failures++;
            $display("FAIL multi_start_count got=%0d exp=3", start_cnt - st0);
        end
    endtask

    task automatic test_delay_zero();
        int t, s, d0, st0;
        logic [31:0] i, q;
        res_if.res_ready = 1'b1;
        d0 = done_cnt;
        do_arm(1, 0, 20);
        tick(2);
        st0 = start_cnt;
        pulse_trigger(t);
        wait_start(10, s);
        checks++;
        if (s != t + 1) begin
            failures++;
            $display("FAIL delay0_latency got=%0d exp=1", s - t);
        end
        tick(3);
        checks++;
        if (start_cnt - st0 != 1) begin
            failures++;
            $display("FAIL delay0_single_pulse got=%0d exp=1", start_cnt - st0);
        end
        send_iq(0, 1'b1, i, q);
        tick(3);
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL delay0_done got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int t, s, d0;
        d0 = done_cnt;
        do_arm(1, 0, 10);
        tick(2);
        pulse_trigger(t);
        wait_start(10, s);
        tick(74);
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1 || s < 0) begin
            failures++;
            $display("FAIL timeout_early got timeout=%b busy=%b start=%0d exp timeout=0 busy=1", timeout_err, busy, s);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_expiry got timeout=%b busy=%b exp timeout=1 busy=0", timeout_err, busy);
        end
        tick(3);
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL timeout_no_done got=%0d exp=0", done_cnt - d0);
        end
    endtask

    task automatic test_zero_shots();
        int d0;
        d0 = done_cnt;
        do_arm(0, 3, 10);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_shots got done=%b busy=%b timeout=%b exp done=1 busy=0 timeout=0", done, busy, timeout_err);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL zero_shots_pulse got done=%b busy=%b count=%0d exp done=0 busy=0 count=1", done, busy, done_cnt - d0);
        end
    endtask

    task automatic test_timeout_boundary();
        int t, s, d0;
        logic [31:0] i, q;
        res_if.res_ready = 1'b1;
        d0 = done_cnt;
        do_arm(1, 0, 10);
        tick(2);
        pulse_trigger(t);
        wait_start(10, s);
        tick(74);
        send_iq(0, 1'b1, i, q);
        checks++;
        if (timeout_err !== 1'b0 || res_if.res_valid !== 1'b1) begin
            failures++;
            $display("FAIL iq_beats_timeout got timeout=%b valid=%b exp timeout=0 valid=1", timeout_err, res_if.res_valid);
        end
        tick(2);
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL iq_beats_timeout_done got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_overrun();
        int t, s, st0, bad;
        logic [31:0] i, q;
        res_if.res_ready = 1'b0;
        do_arm(2, 2, 50);
        tick(2);
        pulse_trigger(t);
        wait_start(10, s);
        checks++;
        if (s != t + 3) begin
            failures++;
            $display("FAIL overrun_start_latency got=%0d exp=3", s - t);
        end
        tick(3);
        send_iq(0, 1'b1, i, q);
        st0 = start_cnt;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (res_if.res_valid !== 1'b1 || res_if.res_i !== i || res_if.res_q !== q || res_if.res_shot !== 16'd0)
                bad++;
            trigger = (k == 10);
            tick();
        end
        trigger = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable got unstable_cycles=%0d exp=0", bad);
        end
        checks++;
        if (overrun !== 1'b1 || start_cnt != st0) begin
            failures++;
            $display("FAIL overrun_flag got overrun=%b starts=%0d exp overrun=1 starts=0", overrun, start_cnt - st0);
        end
        res_if.res_ready = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || res_if.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_next_shot got busy=%b valid=%b exp busy=1 valid=0", busy, res_if.res_valid);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        int t, s, d0, st0;
        logic [31:0] i, q;
        d0  = done_cnt;
        st0 = start_cnt;
        do_arm(2, 20, 10);
        tick(2);
        pulse_trigger(t);
        tick(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || start_collect !== 1'b0) begin
            failures++;
            $display("FAIL abort_delay got busy=%b start=%b exp busy=0 start=0", busy, start_collect);
        end
        tick(25);
        checks++;
        if (start_cnt != st0 || done_cnt != d0) begin
            failures++;
            $display("FAIL abort_delay_quiet got starts=%0d dones=%0d exp 0 0", start_cnt - st0, done_cnt - d0);
        end
        res_if.res_ready = 1'b0;
        do_arm(1, 0, 10);
        tick(2);
        pulse_trigger(t);
        wait_start(10, s);
        tick(2);
        send_iq(0, 1'b0, i, q);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (res_if.res_valid !== 1'b0 || busy !== 1'b0 || s < 0) begin
            failures++;
            $display("FAIL abort_hold got valid=%b busy=%b start=%0d exp valid=0 busy=0", res_if.res_valid, busy, s);
        end
        res_if.res_ready = 1'b1;
        tick(3);
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d exp=0", done_cnt - d0);
        end
    endtask

    task automatic test_arm_while_busy();
        int t, s, d0;
        logic [31:0] i, q;
        res_if.res_ready = 1'b1;
        d0 = done_cnt;
        do_arm(2, 0, 10);
        do_arm(5, 3, 10);
        for (int n = 0; n < 2; n++) begin
            tick(2);
            pulse_trigger(t);
            wait_start(10, s);
            checks++;
            if (s != t + 1) begin
                failures++;
                $display("FAIL busy_arm_latency shot=%0d got=%0d exp=1", n, s - t);
            end
            tick(3);
            send_iq(n, 1'b1, i, q);
            tick(2);
        end
        tick(2);
        checks++;
        if (busy !== 1'b0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL busy_arm_ignored got busy=%b dones=%0d exp busy=0 dones=1", busy, done_cnt - d0);
        end
    endtask

    initial begin
        reset            = 1'b1;
        arm              = 1'b0;
        abort            = 1'b0;
        num_shots        = '0;
        delay_time       = '0;
        sample_length    = '0;
        trigger          = 1'b0;
        iq_valid         = 1'b0;
        i_val            = '0;
        q_val            = '0;
        res_if.res_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        test_reset();
        test_multi_shot();
        test_delay_zero();
        test_timeout();
        test_zero_shots();
        test_timeout_boundary();
        test_overrun();
        test_abort();
        test_arm_while_busy();
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
